pdm_cic_decimator: RTL

//  Audio front end for the spectrogram display: drives a PDM microphone clock and samples its 1-bit stream.
//  A 3rd-order CIC decimator turns the stream into signed 18-bit PCM.

---
 rtl/pdm_cic_decimator_pkg.sv | 21 ++
 rtl/pdm_cic_decimator_clkgen.sv | 33 +++
 rtl/pdm_cic_decimator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pdm_cic_decimator_pkg.sv
// Shared audio definitions for the PDM front end and the display sample buffer:
// sample width, saturation limits, comb FSM state encoding and warm-up count.
package pdm_cic_decimator_pkg;

    localparam int AUDIO_W = 18;
    localparam logic signed [AUDIO_W-1:0] AUDIO_MAX = 18'sd131071;
    localparam logic signed [AUDIO_W-1:0] AUDIO_MIN = -18'sd131072;

    // Number of decimated results discarded after reset while the combs fill.
    localparam int WARMUP = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_C1   = 3'd1,
        ST_C2   = 3'd2,
        ST_C3   = 3'd3,
        ST_DCB  = 3'd4,
        ST_OUT  = 3'd5
    } cic_state_t;

endpackage

// File: rtl/pdm_cic_decimator_clkgen.sv
// PDM microphone clock generator: divides CLK by PDM_DIV, drives a registered
// 50% duty PDM_CLK and flags the last high-phase cycle as the bit sample tick.
module pdm_clkgen
    import pdm_cic_decimator_pkg::*;
#(
    parameter int PDM_DIV = 30
) (
    input  logic CLK,
    input  logic nRST,
    output logic PDM_CLK,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(PDM_DIV);
    localparam int HALF  = PDM_DIV / 2;

    logic [CNT_W-1:0] div_cnt;

    // The microphone drives data on the falling edge, so sample at the end of the high phase.
    assign bit_tick = (div_cnt == CNT_W'(HALF - 1));

    // Free-running divider; PDM_CLK goes high on the first edge after reset release.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            div_cnt <= '0;
            PDM_CLK <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == CNT_W'(PDM_DIV - 1)) ? '0 : div_cnt + 1'b1;
            PDM_CLK <= (div_cnt < CNT_W'(HALF));
        end
    end

endmodule

// File: rtl/pdm_cic_decimator.sv
// 3rd-order CIC decimator for a 1-bit PDM microphone, producing signed 18-bit
// PCM on ADATA0 with a one-cycle ADATARDY strobe.
// Optional build macro: DC_BLOCK_EN inserts a first-order DC-removal stage
// after saturation (one extra FSM state, one cycle more latency).
module pdm_cic_decimator
    import pdm_cic_decimator_pkg::*;
#(
    parameter int PDM_DIV   = 30,
    parameter int DECIM     = 64,
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    output logic                      PDM_CLK,
    input  logic                      PDM_DAT,
    output logic signed [AUDIO_W-1:0] ADATA0,
    output logic                      ADATARDY
);

    localparam int BCNT_W = $clog2(DECIM);
    localparam int WARM_W = $clog2(WARMUP + 1);

    function automatic logic signed [AUDIO_W-1:0] sat_audio(input logic signed [31:0] v);
        if (v > 32'(AUDIO_MAX)) return AUDIO_MAX;
        if (v < 32'(AUDIO_MIN)) return AUDIO_MIN;
        return v[AUDIO_W-1:0];
    endfunction

    logic                     bit_tick;
    logic                     pdm_sync_p0;
    logic                     pdm_sync_p1;
    logic signed [ACC_W-1:0]  x_p1;
    logic signed [ACC_W-1:0]  i1, i2, i3;
    logic [BCNT_W-1:0]        bit_cnt;
    logic                     last_bit;
    logic signed [ACC_W-1:0]  cap;
    logic signed [ACC_W-1:0]  z1, z2, z3;
    logic signed [ACC_W-1:0]  d1, d2, d3;
    logic signed [31:0]       d3_scaled;
    logic [WARM_W-1:0]        warm_cnt;
    logic                     vld_p0;
    cic_state_t               state;

    pdm_clkgen #(
        .PDM_DIV (PDM_DIV)
    ) u_clkgen (
        .CLK      (CLK),
        .nRST     (nRST),
        .PDM_CLK  (PDM_CLK),
        .bit_tick (bit_tick)
    );

    // Bit 1 maps to +1 (000..01), bit 0 to -1 (111..11).
    assign x_p1      = {{(ACC_W-1){~pdm_sync_p1}}, 1'b1};
    assign last_bit  = bit_tick && (bit_cnt == BCNT_W'(DECIM - 1));
    assign d3_scaled = 32'(d3) >>> OUT_SHIFT;

    // Two-flop synchroniser on the microphone data line.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pdm_sync_p0 <= 1'b0;
            pdm_sync_p1 <= 1'b0;
        end else begin
            pdm_sync_p0 <= PDM_DAT;
            pdm_sync_p1 <= pdm_sync_p0;
        end
    end

    // Integrator cascade and decimation counter, advanced once per PDM bit; wraps modulo 2^ACC_W.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            i1      <= '0;
            i2      <= '0;
            i3      <= '0;
            bit_cnt <= '0;
        end else if (bit_tick) begin
            i1      <= i1 + x_p1;
            i2      <= i2 + i1;
            i3      <= i3 + i2;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

`ifdef DC_BLOCK_EN
    logic signed [AUDIO_W-1:0] dc_x_prev;
    logic signed [AUDIO_W-1:0] dc_y_prev;
    logic signed [AUDIO_W-1:0] dc_x;
    logic signed [31:0]        dc_y_raw;

    assign dc_x     = sat_audio(d3_scaled);
    assign dc_y_raw = 32'(dc_x) - 32'(dc_x_prev) + 32'(dc_y_prev) - (32'(dc_y_prev) >>> 10);
`endif

    // Comb FSM: one comb stage per cycle after each decimated capture, then the output write.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_IDLE;
            cap       <= '0;
            z1        <= '0;
            z2        <= '0;
            z3        <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            warm_cnt  <= '0;
            vld_p0    <= 1'b0;
            ADATA0    <= '0;
`ifdef DC_BLOCK_EN
            dc_x_prev <= '0;
            dc_y_prev <= '0;
`endif
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (last_bit) begin
                        cap   <= i3 + i2;
                        state <= ST_C1;
                    end
                end
                ST_C1: begin
                    d1    <= cap - z1;
                    z1    <= cap;
                    state <= ST_C2;
                end
                ST_C2: begin
                    d2    <= d1 - z2;
                    z2    <= d1;
                    state <= ST_C3;
                end
                ST_C3: begin
                    d3    <= d2 - z3;
                    z3    <= d2;
`ifdef DC_BLOCK_EN
                    state <= ST_DCB;
`else
                    state <= ST_OUT;
`endif
                end
`ifdef DC_BLOCK_EN
                ST_DCB: begin
                    dc_x_prev <= dc_x;
                    dc_y_prev <= sat_audio(dc_y_raw);
                    state     <= ST_OUT;
                end
`endif
                ST_OUT: begin
                    if (warm_cnt == WARM_W'(WARMUP)) begin
`ifdef DC_BLOCK_EN
                        ADATA0 <= dc_y_prev;
`else
                        ADATA0 <= sat_audio(d3_scaled);
`endif
                        vld_p0 <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output strobe follows the ADATA0 write by one cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ADATARDY <= 1'b0;
        end else begin
            ADATARDY <= vld_p0;
        end
    end

endmodule
